// File: rtl/ip_opll_write_master.sv
`default_nettype none
// ============================================================================
// Module      : ip_opll_write_master
// Description : MSX-bus initiator turning one (register, value) request into
//               the two-phase OPLL write: register number to ADDR_PORT, then
//               value to DATA_PORT, with programmable setup / strobe / hold
//               timing and the YM2413 post-write recovery waits. An optional
//               enable write is issued once after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_opll_write_master #(
  parameter bit          USE_IOREQ = 1'b0,
  parameter logic [15:0] ADDR_PORT = 16'h7FF4,
  parameter logic [15:0] DATA_PORT = 16'h7FF5,
  parameter bit          INIT_EN   = 1'b1,
  parameter logic [15:0] INIT_PORT = 16'h7FF6,
  parameter logic [7:0]  INIT_DATA = 8'h01,
  parameter int unsigned T_SETUP   = 6,
  parameter int unsigned T_WR      = 6,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned WAIT_ADDR = 78,
  parameter int unsigned WAIT_DATA = 510
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  reg_data,
  output logic        ready,
  output logic        n_sltsl,
  output logic        n_ioreq,
  output logic        n_wr,
  output logic [15:0] address,
  output logic [7:0]  wdata,
  output logic        wdata_oe
);

  // Counter reload values: a phase lasting N cycles is loaded with N-1 and
  // left when the counter reads zero.
  localparam logic [9:0] C_SETUP_LD = 10'(T_SETUP - 1);
  localparam logic [9:0] C_WR_LD    = 10'(T_WR - 1);
  localparam logic [9:0] C_HOLD_LD  = 10'(T_HOLD - 1);
  localparam logic [9:0] C_WA_LD    = 10'(WAIT_ADDR - 1);
  localparam logic [9:0] C_WD_LD    = 10'(WAIT_DATA - 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  // Elaboration-time range check of the timing parameters.
  if (T_SETUP < 1 || T_SETUP > 15 || T_WR < 1 || T_WR > 15 ||
      T_HOLD < 1 || T_HOLD > 15) begin : g_bad_strobe_timing
    $error("ip_opll_write_master: T_SETUP/T_WR/T_HOLD must be 1..15");
  end
  if (WAIT_ADDR < 1 || WAIT_ADDR > 1023 ||
      WAIT_DATA < 1 || WAIT_DATA > 1023) begin : g_bad_wait_timing
    $error("ip_opll_write_master: WAIT_ADDR/WAIT_DATA must be 1..1023");
  end

  state_t      state, state_nx;
  logic [9:0]  cnt, cnt_nx;
  logic        ph, ph_nx;             // 0: register-number write, 1: value write
  logic [7:0]  data_lat, data_lat_nx; // value held for the second phase
  logic [15:0] address_r, address_nx;
  logic [7:0]  wdata_r, wdata_nx;
  logic        ready_r, ready_nx;
  logic        sel_n_r, sel_n_nx;
  logic        n_wr_r, n_wr_nx;
  logic        oe_r, oe_nx;

  // Next-state, counter and bus-value decode; bus outputs follow the next state
  // so they are registered and change on the same edge as the state.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ph_nx       = ph;
    data_lat_nx = data_lat;
    address_nx  = address_r;
    wdata_nx    = wdata_r;

    case (state)
      S_INIT: begin
        // The enable write behaves as a value-phase write so its recovery is
        // WAIT_DATA and it returns to IDLE afterwards.
        state_nx   = S_SETUP;
        cnt_nx     = C_SETUP_LD;
        ph_nx      = 1'b1;
        address_nx = INIT_PORT;
        wdata_nx   = INIT_DATA;
      end
      S_IDLE: begin
        if (req && ready_r) begin
          state_nx    = S_SETUP;
          cnt_nx      = C_SETUP_LD;
          ph_nx       = 1'b0;
          address_nx  = ADDR_PORT;
          wdata_nx    = reg_addr;
          data_lat_nx = reg_data;
        end
      end
      S_SETUP: begin
        if (cnt == 10'd0) begin
          state_nx = S_STROBE;
          cnt_nx   = C_WR_LD;
        end else begin
          cnt_nx = cnt - 10'd1;
        end
      end
      S_STROBE: begin
        if (cnt == 10'd0) begin
          state_nx = S_HOLD;
          cnt_nx   = C_HOLD_LD;
        end else begin
          cnt_nx = cnt - 10'd1;
        end
      end
      S_HOLD: begin
        if (cnt == 10'd0) begin
          state_nx = S_WAIT;
          cnt_nx   = ph ? C_WD_LD : C_WA_LD;
        end else begin
          cnt_nx = cnt - 10'd1;
        end
      end
      S_WAIT: begin
        if (cnt == 10'd0) begin
          if (!ph) begin
            // Straight into the value write, no idle cycle in between.
            state_nx   = S_SETUP;
            cnt_nx     = C_SETUP_LD;
            ph_nx      = 1'b1;
            address_nx = DATA_PORT;
            wdata_nx   = data_lat;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt - 10'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    sel_n_nx = !((state_nx == S_SETUP) || (state_nx == S_STROBE) ||
                 (state_nx == S_HOLD));
    oe_nx    = !sel_n_nx;
    n_wr_nx  = (state_nx != S_STROBE);
    ready_nx = (state_nx == S_IDLE);
  end

  // State, counter and registered bus outputs; reset abandons any cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT_EN ? S_INIT : S_IDLE;
      cnt       <= 10'd0;
      ph        <= 1'b0;
      data_lat  <= 8'h00;
      address_r <= 16'h0000;
      wdata_r   <= 8'h00;
      ready_r   <= 1'b0;
      sel_n_r   <= 1'b1;
      n_wr_r    <= 1'b1;
      oe_r      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ph        <= ph_nx;
      data_lat  <= data_lat_nx;
      address_r <= address_nx;
      wdata_r   <= wdata_nx;
      ready_r   <= ready_nx;
      sel_n_r   <= sel_n_nx;
      n_wr_r    <= n_wr_nx;
      oe_r      <= oe_nx;
    end
  end

  // Route the select window to the slot or I/O request line; the other stays high.
  if (USE_IOREQ) begin : g_sel_ioreq
    assign n_ioreq = sel_n_r;
    assign n_sltsl = 1'b1;
  end else begin : g_sel_sltsl
    assign n_sltsl = sel_n_r;
    assign n_ioreq = 1'b1;
  end

  assign ready    = ready_r;
  assign n_wr     = n_wr_r;
  assign address  = address_r;
  assign wdata    = wdata_r;
  assign wdata_oe = oe_r;

endmodule
`default_nettype wire

// File: tb/tb_ip_opll_write_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_opll_write_master
// Description : Self-checking bench for ip_opll_write_master. Two instances:
//               memory-mapped defaults and an I/O-mapped variant. A cycle
//               model derived from write timing arithmetic checks every output
//               on every cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_opll_write_master;

  localparam int TS = 6;
  localparam int TW = 6;
  localparam int TH = 1;
  localparam int WAIT_A = 78;
  localparam int WAIT_D = 510;
  localparam int ACT = TS + TW + TH;     // cycles with select low
  localparam int WA = ACT + WAIT_A;      // address-phase write length
  localparam int WD = ACT + WAIT_D;      // value-phase / enable write length

  localparam int M_RST  = 0;
  localparam int M_INIT = 1;
  localparam int M_IDLE = 2;
  localparam int M_BUSY = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, req0, rst1, req1;
  logic [7:0]  ra0, rd0, ra1, rd1;
  logic [1:0]  rdy_o, nsl_o, nio_o, nwr_o, oe_o;
  logic [15:0] adr_o [2];
  logic [7:0]  wd_o [2];

  int n_checks = 0;
  int n_fail = 0;

  ip_opll_write_master dut0 (
    .clk(clk), .reset(rst0), .req(req0), .reg_addr(ra0), .reg_data(rd0),
    .ready(rdy_o[0]), .n_sltsl(nsl_o[0]), .n_ioreq(nio_o[0]), .n_wr(nwr_o[0]),
    .address(adr_o[0]), .wdata(wd_o[0]), .wdata_oe(oe_o[0])
  );

  ip_opll_write_master #(
    .USE_IOREQ(1'b1), .ADDR_PORT(16'h007C), .DATA_PORT(16'h007D)
  ) dut1 (
    .clk(clk), .reset(rst1), .req(req1), .reg_addr(ra1), .reg_data(rd1),
    .ready(rdy_o[1]), .n_sltsl(nsl_o[1]), .n_ioreq(nio_o[1]), .n_wr(nwr_o[1]),
    .address(adr_o[1]), .wdata(wd_o[1]), .wdata_oe(oe_o[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode [2];
  int          m_k [2];
  bit          m_valid [2];
  logic [7:0]  m_la [2];
  logic [7:0]  m_ld [2];
  logic [15:0] m_last_a [2];
  logic [7:0]  m_last_d [2];

  function automatic logic [15:0] p_aport(input int i);
    return (i == 0) ? 16'h7FF4 : 16'h007C;
  endfunction
  function automatic logic [15:0] p_dport(input int i);
    return (i == 0) ? 16'h7FF5 : 16'h007D;
  endfunction

  // Packed {ready, n_sltsl, n_ioreq, n_wr, oe, address, wdata}.
  function automatic logic [28:0] model_out(input int i);
    int j;
    logic sel, wr, rdy;
    logic [15:0] a;
    logic [7:0] d;
    j = -1; rdy = 1'b0; a = m_last_a[i]; d = m_last_d[i];
    case (m_mode[i])
      M_RST:  begin a = 16'h0; d = 8'h0; end
      M_INIT: begin j = m_k[i]; a = 16'h7FF6; d = 8'h01; end
      M_IDLE: rdy = 1'b1;
      default: begin
        if (m_k[i] < WA) begin j = m_k[i]; a = p_aport(i); d = m_la[i]; end
        else begin j = m_k[i] - WA; a = p_dport(i); d = m_ld[i]; end
      end
    endcase
    sel = (j >= 0) && (j < ACT);
    wr  = (j >= TS) && (j < TS + TW);
    if (i == 0) return {rdy, ~sel, 1'b1, ~wr, sel, a, d};
    return {rdy, 1'b1, ~sel, ~wr, sel, a, d};
  endfunction

  task automatic model_step(input int i);
    logic r, q;
    logic [7:0] ra, rd;
    r  = (i == 0) ? rst0 : rst1;
    q  = (i == 0) ? req0 : req1;
    ra = (i == 0) ? ra0 : ra1;
    rd = (i == 0) ? rd0 : rd1;
    if (r) begin
      m_valid[i] = 1'b1; m_mode[i] = M_RST; m_last_a[i] = 16'h0; m_last_d[i] = 8'h0;
    end else if (m_valid[i]) begin
      case (m_mode[i])
        M_RST: begin m_mode[i] = M_INIT; m_k[i] = 0; end
        M_INIT: begin
          m_k[i]++;
          if (m_k[i] == WD) begin
            m_mode[i] = M_IDLE; m_last_a[i] = 16'h7FF6; m_last_d[i] = 8'h01;
          end
        end
        M_IDLE: if (q) begin
          m_mode[i] = M_BUSY; m_k[i] = 0; m_la[i] = ra; m_ld[i] = rd;
        end
        default: begin
          m_k[i]++;
          if (m_k[i] == WA + WD) begin
            m_mode[i] = M_IDLE; m_last_a[i] = p_dport(i); m_last_d[i] = m_ld[i];
          end
        end
      endcase
    end
  endtask

  // Compare every output of both instances each cycle, then advance the model
  // with the inputs the next rising edge will sample.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i])
        check($sformatf("bus%0d", i),
              {rdy_o[i], nsl_o[i], nio_o[i], nwr_o[i], oe_o[i], adr_o[i], wd_o[i]},
              model_out(i));
      model_step(i);
    end
  end

  // ---------------- directed observation of dut0 ----------------
  int         sel_lo_cnt, wr_lo_cnt;
  int         ev_sf[$], ev_sr[$], ev_wf[$];
  logic [23:0] bus_q[$];

  function automatic logic [23:0] q_at(input int k);
    if (k < bus_q.size()) return bus_q[k];
    return 24'hFFFFFF;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic observe(input int maxc, input int drop_at, input int chg_at,
                         input logic [7:0] ca, input logic [7:0] cd, output int n);
    logic ps, pw;
    sel_lo_cnt = 0; wr_lo_cnt = 0;
    ev_sf.delete(); ev_sr.delete(); ev_wf.delete(); bus_q.delete();
    ps = nsl_o[0]; pw = nwr_o[0]; n = 0;
    do begin
      step(); n++;
      if (n == drop_at) req0 = 1'b0;
      if (n == chg_at) begin ra0 = ca; rd0 = cd; end
      if (!nsl_o[0]) sel_lo_cnt++;
      if (!nwr_o[0]) wr_lo_cnt++;
      if (ps && !nsl_o[0]) ev_sf.push_back(n);
      if (!ps && nsl_o[0]) ev_sr.push_back(n);
      if (pw && !nwr_o[0]) begin
        ev_wf.push_back(n);
        bus_q.push_back({adr_o[0], wd_o[0]});
      end
      ps = nsl_o[0]; pw = nwr_o[0];
    end while (!rdy_o[0] && n < maxc);
  endtask

  bit done1 = 1'b0;

  initial begin
    int n, k;
    rst0 = 1'b1; req0 = 1'b0; ra0 = 8'h00; rd0 = 8'h00;

    // 1: reset then the single enable write 7FF6=01
    repeat (150) step();
    rst0 = 1'b0;
    observe(700, 0, 0, 8'h00, 8'h00, n);
    check("init_ready_latency", n, 524);
    check("init_sel_low_cycles", sel_lo_cnt, 13);
    check("init_nwr_low_cycles", wr_lo_cnt, 6);
    check("init_write_count", bus_q.size(), 1);
    check("init_write", q_at(0), 24'h7FF601);

    // 2: single request 16/20
    ra0 = 8'h16; rd0 = 8'h20; req0 = 1'b1;
    observe(700, 1, 0, 8'h00, 8'h00, n);
    check("t2_ready_latency", n, 615);
    check("t2_events", {ev_sf.size(), ev_sr.size(), ev_wf.size()}, {32'd2, 32'd2, 32'd2});
    if (ev_sf.size() > 1 && ev_sr.size() > 0 && ev_wf.size() > 0) begin
      check("t2_sel_to_nwr", ev_wf[0] - ev_sf[0], 6);
      check("t2_addr_to_data_gap", ev_sf[1] - ev_sr[0], 78);
    end
    check("t2_write0", q_at(0), 24'h7FF416);
    check("t2_write1", q_at(1), 24'h7FF520);

    // 3: req held high, back-to-back; inputs changed mid-transaction
    ra0 = 8'h0E; rd0 = 8'h30; req0 = 1'b1;
    observe(700, 0, 300, 8'h10, 8'hAC, n);
    check("t3a_latency", n, 615);
    check("t3a_write0", q_at(0), 24'h7FF40E);
    check("t3a_write1", q_at(1), 24'h7FF530);
    observe(700, 1, 300, 8'h99, 8'h99, n);
    check("t3b_latency", n, 615);
    check("t3b_write0", q_at(0), 24'h7FF410);
    check("t3b_write1", q_at(1), 24'h7FF5AC);

    // 5: reset during the strobe
    ra0 = 8'h30; rd0 = 8'h11; req0 = 1'b1;
    step();
    req0 = 1'b0;
    k = 0;
    while (nwr_o[0] && k < 20) begin step(); k++; end
    check("t5_strobe_reached", nwr_o[0], 1'b0);
    check("t5_strobe_bus", {adr_o[0], wd_o[0]}, 24'h7FF430);
    repeat (2) step();
    rst0 = 1'b1;
    step();
    check("t5_after_reset",
          {rdy_o[0], nsl_o[0], nio_o[0], nwr_o[0], oe_o[0], adr_o[0], wd_o[0]},
          {5'b01110, 16'h0000, 8'h00});
    rst0 = 1'b0;
    observe(700, 0, 0, 8'h00, 8'h00, n);
    check("t5_init_latency", n, 524);
    check("t5_init_write", q_at(0), 24'h7FF601);
    check("t5_init_sel_low", sel_lo_cnt, 13);

    k = 0;
    while (!done1 && k < 3000) begin step(); k++; end
    check("dut1_done", done1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // 4: I/O-mapped instance, ports 007C/007D
  initial begin
    int k1, io_lo, sl_lo;
    logic pw1;
    logic [23:0] q1[$];
    rst1 = 1'b1; req1 = 1'b0; ra1 = 8'h00; rd1 = 8'h00;
    repeat (10) step();
    rst1 = 1'b0;
    k1 = 0;
    while (!rdy_o[1] && k1 < 700) begin step(); k1++; end
    check("io_init_latency", k1, 524);
    ra1 = 8'h20; rd1 = 8'h17; req1 = 1'b1;
    step();
    req1 = 1'b0;
    io_lo = 0; sl_lo = 0; pw1 = 1'b1;
    for (int c = 0; c < 620; c++) begin
      if (!nio_o[1]) io_lo++;
      if (!nsl_o[1]) sl_lo++;
      if (pw1 && !nwr_o[1]) q1.push_back({adr_o[1], wd_o[1]});
      pw1 = nwr_o[1];
      step();
    end
    check("io_ioreq_low_cycles", io_lo, 26);
    check("io_sltsl_low_cycles", sl_lo, 0);
    check("io_write_count", q1.size(), 2);
    check("io_write0", (q1.size() > 0) ? q1[0] : 24'hFFFFFF, 24'h007C20);
    check("io_write1", (q1.size() > 1) ? q1[1] : 24'hFFFFFF, 24'h007D17);
    check("io_ready_end", rdy_o[1], 1'b1);
    done1 = 1'b1;
  end

endmodule
`default_nettype wire
